// File: rtl/fm_sb_pkg.sv
// Shared types for the fast-monitoring spy-buffer controller: playback mode
// encoding, controller state encoding and the valid/data stream record.
package fm_sb_pkg;

  localparam int FM_PB_MODE_W  = 2;
  localparam int FM_MON_DW_MAX = 256;

  // Playback mode field as delivered by the FM_CTRL register block.
  typedef enum logic [FM_PB_MODE_W-1:0] {
    FM_PB_CAPTURE = 2'b00,
    FM_PB_ONCE    = 2'b01,
    FM_PB_LOOP    = 2'b10,
    FM_PB_HOLD    = 2'b11
  } fm_pb_mode_t;

  // Controller states.
  typedef enum logic [2:0] {
    FM_ST_IDLE    = 3'd0,
    FM_ST_CAPTURE = 3'd1,
    FM_ST_POST    = 3'd2,
    FM_ST_FROZEN  = 3'd3,
    FM_ST_PLAY    = 3'd4
  } fm_sb_ctrl_state_t;

  // Valid/data pair used by wrappers for the monitored and playback streams.
  typedef struct packed {
    logic                     vld;
    logic [FM_MON_DW_MAX-1:0] data;
  } fm_rt_t;

  // True for the two modes that replay buffer contents.
  function automatic logic fm_is_play(input fm_pb_mode_t m);
    return (m == FM_PB_ONCE) || (m == FM_PB_LOOP);
  endfunction

endpackage

// File: rtl/fm_sb_ptr.sv
// AW-bit wrapping pointer/counter with synchronous clear and count enable.
// Wrap from 2**AW-1 to 0 is the natural modulo behaviour of the adder.
module fm_sb_ptr #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [AW-1:0] ptr
);

  // Clear has priority over increment so a pointer can be restarted mid-stream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= ptr + AW'(1);
    end
  end

endmodule

// File: rtl/fm_sb_ctrl.sv
// Spy-buffer controller: writes the monitored stream into an external
// simple-dual-port RAM as a circular buffer, freezes a programmable number
// of words after a trigger, and replays the buffer once or in a loop.
module fm_sb_ctrl
  import fm_sb_pkg::*;
#(
  parameter int DW        = 256,
  parameter int AW        = 10,
  parameter int PB_MODE_W = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PB_MODE_W-1:0] pb_mode,
  input  logic [AW-1:0]        post_trig_cnt,
  input  logic                 trig,
  input  logic                 rearm,
  input  logic [AW-1:0]        pb_len,
  input  logic [DW-1:0]        in_data,
  input  logic                 in_vld,
  output logic                 ram_we,
  output logic [AW-1:0]        ram_waddr,
  output logic [DW-1:0]        ram_wdata,
  output logic                 ram_re,
  output logic [AW-1:0]        ram_raddr,
  input  logic [DW-1:0]        ram_rdata,
  output logic [DW-1:0]        pb_data,
  output logic                 pb_vld,
  output logic                 frozen,
  output logic [AW-1:0]        trig_addr,
  output logic                 busy
);

  fm_sb_ctrl_state_t state_reg;
  fm_pb_mode_t       mode;
  fm_pb_mode_t       play_mode_reg;
  logic              once_done_reg;

  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW-1:0] ptcnt;
  logic [AW-1:0] ptcnt_inc;

  logic wr_fire;
  logic rd_fire;
  logic rd_last;
  logic trig_take;
  logic post_hit;
  logic post_wr;
  logic rptr_clr;

  logic          ram_we_reg;
  logic [AW-1:0] ram_waddr_reg;
  logic [DW-1:0] ram_wdata_reg;
  logic          ram_re_reg;
  logic [AW-1:0] ram_raddr_reg;
  logic          pb_vld_reg;
  logic          frozen_reg;
  logic          busy_reg;
  logic [AW-1:0] trig_addr_reg;

  assign mode      = fm_pb_mode_t'(pb_mode);
  assign ptcnt_inc = ptcnt + AW'(1);

  // Per-cycle datapath decisions derived from the current state and inputs.
  always_comb begin
    wr_fire   = 1'b0;
    rd_fire   = 1'b0;
    trig_take = 1'b0;
    case (state_reg)
      FM_ST_CAPTURE: begin
        wr_fire   = in_vld && (mode == FM_PB_CAPTURE);
        trig_take = trig && (mode == FM_PB_CAPTURE);
      end
      // Post-trigger writes stop as soon as the programmed count is reached,
      // which also covers a zero count (no writes after the trigger word).
      FM_ST_POST: begin
        wr_fire = in_vld && (mode != FM_PB_HOLD) && (ptcnt != post_trig_cnt);
      end
      // A read is issued every cycle while the mode that started playback holds;
      // any mode change lets the last issued word drain and stops reading.
      FM_ST_PLAY: begin
        rd_fire = (mode == play_mode_reg);
      end
      default: begin
        wr_fire = 1'b0;
      end
    endcase
  end

  assign rd_last  = rd_fire && (rptr == pb_len);
  assign post_wr  = wr_fire && (state_reg == FM_ST_POST);
  assign post_hit = (ptcnt == post_trig_cnt) ||
                    (post_wr && (ptcnt_inc == post_trig_cnt));
  // The read pointer returns to 0 at the end of every pass and on abort, so
  // every playback burst starts at address 0.
  assign rptr_clr = (state_reg == FM_ST_PLAY) && (!rd_fire || rd_last);

  fm_sb_ptr #(.AW(AW)) u_wptr (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .en  (wr_fire),
    .ptr (wptr)
  );

  fm_sb_ptr #(.AW(AW)) u_ptcnt (
    .clk (clk),
    .rst (rst),
    .clr (trig_take),
    .en  (post_wr),
    .ptr (ptcnt)
  );

  fm_sb_ptr #(.AW(AW)) u_rptr (
    .clk (clk),
    .rst (rst),
    .clr (rptr_clr),
    .en  (rd_fire),
    .ptr (rptr)
  );

  // Controller state and registered outputs. frozen/busy trail the state by
  // one cycle so frozen never overlaps the final RAM write pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= FM_ST_IDLE;
      play_mode_reg <= FM_PB_CAPTURE;
      once_done_reg <= 1'b0;
      ram_we_reg    <= 1'b0;
      ram_waddr_reg <= '0;
      ram_wdata_reg <= '0;
      ram_re_reg    <= 1'b0;
      ram_raddr_reg <= '0;
      pb_vld_reg    <= 1'b0;
      frozen_reg    <= 1'b0;
      busy_reg      <= 1'b0;
      trig_addr_reg <= '0;
    end else begin
      ram_we_reg <= wr_fire;
      if (wr_fire) begin
        ram_waddr_reg <= wptr;
        ram_wdata_reg <= in_data;
      end
      ram_re_reg <= rd_fire;
      if (rd_fire) begin
        ram_raddr_reg <= rptr;
      end
      pb_vld_reg <= ram_re_reg;
      frozen_reg <= (state_reg == FM_ST_FROZEN);
      busy_reg   <= !(state_reg inside {FM_ST_IDLE, FM_ST_FROZEN});

      // A completed single pass is not repeated until the mode leaves PLAY_ONCE.
      if (mode != FM_PB_ONCE) begin
        once_done_reg <= 1'b0;
      end

      case (state_reg)
        FM_ST_IDLE: begin
          if (mode == FM_PB_CAPTURE) begin
            state_reg <= FM_ST_CAPTURE;
          end else if ((mode == FM_PB_LOOP) ||
                       ((mode == FM_PB_ONCE) && !once_done_reg)) begin
            state_reg     <= FM_ST_PLAY;
            play_mode_reg <= mode;
          end
        end
        FM_ST_CAPTURE: begin
          if (mode != FM_PB_CAPTURE) begin
            state_reg <= FM_ST_IDLE;
          end else if (trig) begin
            trig_addr_reg <= wptr;
            state_reg     <= FM_ST_POST;
          end
        end
        FM_ST_POST: begin
          if (mode == FM_PB_HOLD) begin
            state_reg <= FM_ST_IDLE;
          end else if (post_hit) begin
            state_reg <= FM_ST_FROZEN;
          end
        end
        FM_ST_FROZEN: begin
          // rearm outranks both a coincident trig and a playback request.
          if (rearm) begin
            state_reg <= FM_ST_CAPTURE;
          end else if (fm_is_play(mode)) begin
            state_reg     <= FM_ST_PLAY;
            play_mode_reg <= mode;
          end
        end
        FM_ST_PLAY: begin
          if (!rd_fire) begin
            state_reg <= FM_ST_IDLE;
          end else if (rd_last && (play_mode_reg == FM_PB_ONCE)) begin
            state_reg     <= FM_ST_IDLE;
            once_done_reg <= 1'b1;
          end
        end
        default: begin
          state_reg <= FM_ST_IDLE;
        end
      endcase
    end
  end

  assign ram_we    = ram_we_reg;
  assign ram_waddr = ram_waddr_reg;
  assign ram_wdata = ram_wdata_reg;
  assign ram_re    = ram_re_reg;
  assign ram_raddr = ram_raddr_reg;
  assign pb_vld    = pb_vld_reg;
  // RAM read data arrives one cycle after ram_re, aligned with pb_vld; it is
  // gated so pb_data reads as zero whenever no playback word is valid.
  assign pb_data   = pb_vld_reg ? ram_rdata : '0;
  assign frozen    = frozen_reg;
  assign busy      = busy_reg;
  assign trig_addr = trig_addr_reg;

endmodule

// File: tb/tb_fm_sb_ctrl.sv
// Randomized bench for fm_sb_ctrl with a behavioural RAM and a reference
// model of the expected buffer writes and playback stream.
module tb_fm_sb_ctrl;

  localparam int DW    = 256;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    pb_mode = 2'b11;
  logic [AW-1:0] post_trig_cnt = '0;
  logic          trig = 1'b0;
  logic          rearm = 1'b0;
  logic [AW-1:0] pb_len = '0;
  logic [DW-1:0] in_data = '0;
  logic          in_vld = 1'b0;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [DW-1:0] ram_wdata;
  logic          ram_re;
  logic [AW-1:0] ram_raddr;
  logic [DW-1:0] ram_rdata = '0;
  logic [DW-1:0] pb_data;
  logic          pb_vld;
  logic          frozen;
  logic [AW-1:0] trig_addr;
  logic          busy;

  fm_sb_ctrl #(.DW(DW), .AW(AW), .PB_MODE_W(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .pb_mode       (pb_mode),
    .post_trig_cnt (post_trig_cnt),
    .trig          (trig),
    .rearm         (rearm),
    .pb_len        (pb_len),
    .in_data       (in_data),
    .in_vld        (in_vld),
    .ram_we        (ram_we),
    .ram_waddr     (ram_waddr),
    .ram_wdata     (ram_wdata),
    .ram_re        (ram_re),
    .ram_raddr     (ram_raddr),
    .ram_rdata     (ram_rdata),
    .pb_data       (pb_data),
    .pb_vld        (pb_vld),
    .frozen        (frozen),
    .trig_addr     (trig_addr),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // Simple-dual-port RAM with one cycle of read latency.
  logic [DW-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (ram_we) ram[ram_waddr] <= ram_wdata;
    if (ram_re) ram_rdata <= ram[ram_raddr];
  end

  int n_vec = 0;
  int n_err = 0;

  // Reference model state.
  int            cyc = 0;
  int            m_wptr = 0;
  int            m_rptr = 0;
  int            pb_len_m = 0;
  int            rd_count = 0;
  int            exp_trig = 0;
  bit            prev_re = 1'b0;
  logic [DW-1:0] exp_mem [DEPTH];
  int            wq_addr [$];
  int            wq_cyc [$];
  logic [DW-1:0] wq_data [$];
  logic [DW-1:0] pbq [$];

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Observe one cycle of DUT outputs against the expected write and read streams.
  task automatic mon();
    if (ram_we) begin
      if (wq_addr.size() == 0) begin
        check("wr_unexpected", 1, 0);
      end else begin
        check("wr_addr", ram_waddr, wq_addr.pop_front());
        check("wr_data", ram_wdata, wq_data.pop_front());
        check("wr_cycle", cyc, wq_cyc.pop_front());
      end
    end
    if (pb_vld || prev_re) check("pb_vld_lat", pb_vld, prev_re);
    if (pb_vld) begin
      if (pbq.size() == 0) check("pb_unexpected", 1, 0);
      else check("pb_data", pb_data, pbq.pop_front());
    end
    if (ram_re) begin
      if (!prev_re) m_rptr = 0;
      check("rd_addr", ram_raddr, m_rptr);
      pbq.push_back(exp_mem[m_rptr]);
      m_rptr = (m_rptr == pb_len_m) ? 0 : m_rptr + 1;
      rd_count++;
    end
    prev_re = ram_re;
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (!rst) mon();
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // One input cycle; exp_wr says whether the model expects the word stored.
  task automatic drive(input bit vld, input bit exp_wr, input bit t, input bit r);
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom();
    in_data = d;
    in_vld  = vld;
    trig    = t;
    rearm   = r;
    if (vld && exp_wr) begin
      wq_addr.push_back(m_wptr);
      wq_data.push_back(d);
      wq_cyc.push_back(cyc + 1);
      exp_mem[m_wptr] = d;
      m_wptr = (m_wptr + 1) % DEPTH;
    end
    tick();
    in_vld = 1'b0;
    trig   = 1'b0;
    rearm  = 1'b0;
  endtask

  task automatic cap_word(input bit exp_wr);
    while ($urandom_range(0, 3) == 0) tick();
    drive(1'b1, exp_wr, 1'b0, 1'b0);
  endtask

  task automatic wait_re(input int budget);
    int n = 0;
    while (!ram_re && n < budget) begin
      tick();
      n++;
    end
    if (!ram_re) check("re_timeout", 0, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    int ptc;
    int len;
    bit tv;

    // Reset values.
    idle(2);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_re", ram_re, 0);
    check("rst_pb_vld", pb_vld, 0);
    check("rst_frozen", frozen, 0);
    check("rst_busy", busy, 0);
    check("rst_waddr", ram_waddr, 0);

    // Capture five words from address 0.
    rst = 1'b0;
    pb_mode = 2'b00;
    post_trig_cnt = AW'(3);
    tick();
    repeat (5) cap_word(1'b1);
    tick();
    check("cap_busy", busy, 1);
    check("cap_frozen", frozen, 0);

    // Wrap the circular buffer, then advance to address 100.
    repeat (1025) cap_word(1'b1);
    while (m_wptr != 100) cap_word(1'b1);

    // Trigger with data at address 100, three post-trigger words, then frozen.
    exp_trig = m_wptr;
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    repeat (3) cap_word(1'b1);
    repeat (5) cap_word(1'b0);
    idle(2);
    check("trig_addr", trig_addr, exp_trig);
    check("frz_frozen", frozen, 1);
    check("frz_busy", busy, 0);

    // Randomized rearm/trigger rounds; round 0 also fires trig with rearm.
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b0, (k == 0), 1'b1);
      repeat ($urandom_range(3, 20)) cap_word(1'b1);
      if (k == 0) begin
        check("rearm_trig_addr", trig_addr, exp_trig);
        check("rearm_frozen", frozen, 0);
        check("rearm_busy", busy, 1);
      end
      ptc = (k == 1) ? 0 : $urandom_range(1, 4);
      post_trig_cnt = AW'(ptc);
      tv = 1'($urandom_range(0, 1));
      exp_trig = m_wptr;
      drive(tv, 1'b1, 1'b1, 1'b0);
      repeat (ptc) cap_word(1'b1);
      repeat (3) cap_word(1'b0);
      idle(2);
      check("rnd_trig_addr", trig_addr, exp_trig);
      check("rnd_frozen", frozen, 1);
    end

    // Single pass of four words from the frozen buffer.
    pb_len = AW'(3);
    pb_len_m = 3;
    base = rd_count;
    pb_mode = 2'b01;
    idle(12);
    check("once_reads", rd_count - base, 4);
    check("once_busy", busy, 0);
    check("once_frozen", frozen, 0);
    idle(5);
    check("once_norepeat", rd_count - base, 4);

    // Continuous loop over addresses 0,1 then abort.
    pb_mode = 2'b11;
    idle(2);
    pb_len = AW'(1);
    pb_len_m = 1;
    pb_mode = 2'b10;
    wait_re(10);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("loop_gap", ram_re, 1);
    end
    pb_mode = 2'b11;
    idle(4);
    check("abort_re", ram_re, 0);
    check("abort_busy", busy, 0);
    check("abort_drain", pbq.size(), 0);

    // Single pass with a random length, including a length of one word.
    len = $urandom_range(0, 7);
    pb_len = AW'(len);
    pb_len_m = len;
    base = rd_count;
    pb_mode = 2'b01;
    idle(16);
    check("once_rnd_reads", rd_count - base, len + 1);
    pb_mode = 2'b11;
    idle(2);

    // Asynchronous reset in the middle of the post-trigger phase.
    pb_mode = 2'b00;
    tick();
    repeat (4) cap_word(1'b1);
    post_trig_cnt = AW'(20);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    cap_word(1'b1);
    cap_word(1'b1);
    check("pre_rst_we", ram_we, 1);
    #1 rst = 1'b1;
    #1;
    check("arst_ram_we", ram_we, 0);
    check("arst_pb_vld", pb_vld, 0);
    check("arst_busy", busy, 0);
    check("arst_trig_addr", trig_addr, 0);
    check("arst_waddr", ram_waddr, 0);
    check("arst_wdata", ram_wdata, 0);
    m_wptr = 0;
    prev_re = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    repeat (5) cap_word(1'b1);
    idle(3);
    check("post_rst_busy", busy, 1);
    check("wq_drain", wq_addr.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
